// File: rtl/bytebasher_pkg.sv
// Shared definitions for the ByteBasher hole-sensor path: widths, FSM states
// and small combinational helpers on hit codes.
package bytebasher_pkg;

    localparam int HOLE_ID_W               = 2;
    localparam int HIT_CODE_W              = 4;
    localparam int HIT_COUNT_W             = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PULSE        = 2'd1,
        S_WAIT_RELEASE = 2'd2
    } hit_state_e;

    // Index of the lowest set bit; scanning downward lets the lowest bit win.
    function automatic logic [HOLE_ID_W-1:0] lowest_set_index(
        input logic [HIT_CODE_W-1:0] code
    );
        logic [HOLE_ID_W-1:0] idx;
        idx = {HOLE_ID_W{1'b0}};
        for (int i = HIT_CODE_W - 1; i >= 0; i--) begin
            if (code[i]) begin
                idx = HOLE_ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // True when clearing the lowest set bit still leaves a bit set.
    function automatic logic more_than_one_set(
        input logic [HIT_CODE_W-1:0] code
    );
        return ((code & (code - {{(HIT_CODE_W-1){1'b0}}, 1'b1})) != {HIT_CODE_W{1'b0}});
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; the debounced code
// only follows the input after it has held for DEBOUNCE_CYCLES cycles.
module sync_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_db_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_sync_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_db_code;
    logic [CNT_W-1:0] w_cnt_next;

    // Next counter value: restart on any change of the synchronized code.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_sync != r_sync_prev) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_next = CNT_MAX;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Synchronizer, change detector, counter and debounced code registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta      <= {WIDTH{1'b0}};
            r_sync      <= {WIDTH{1'b0}};
            r_sync_prev <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_db_code   <= {WIDTH{1'b0}};
        end else begin
            r_meta      <= i_async;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            r_cnt       <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) begin
                r_db_code <= r_sync;
            end else begin
                r_db_code <= r_db_code;
            end
        end
    end

    assign o_db_code = r_db_code;

endmodule

// File: rtl/hit_decoder.sv
// Turns the debounced Arduino hole code into one pulse per press, with the
// hole index, a multi-hole flag and a saturating hit counter.
module hit_decoder
    import bytebasher_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [HIT_CODE_W-1:0]  ard_hit,
    input  logic                   enable,
    input  logic                   clear_count,
    output logic                   hit_valid,
    output logic [HOLE_ID_W-1:0]   hit_id,
    output logic                   hit_multi,
    output logic [HIT_COUNT_W-1:0] hit_count,
    output logic                   busy
);

    localparam logic [HIT_COUNT_W-1:0] COUNT_MAX = {HIT_COUNT_W{1'b1}};

    logic [HIT_CODE_W-1:0]  w_db_code;
    logic                   w_db_nonzero;
    logic                   w_take_hit;
    hit_state_e             r_state;
    hit_state_e             w_state_next;
    logic                   r_hit_valid;
    logic [HOLE_ID_W-1:0]   r_hit_id;
    logic                   r_hit_multi;
    logic [HIT_COUNT_W-1:0] r_hit_count;
    logic                   r_busy;

    sync_debounce #(
        .WIDTH           (HIT_CODE_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .i_async   (ard_hit),
        .o_db_code (w_db_code)
    );

    assign w_db_nonzero = (w_db_code != {HIT_CODE_W{1'b0}});

    // Next-state logic; a code seen while disabled is swallowed until release.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_db_nonzero && enable) begin
                    w_state_next = S_PULSE;
                end else if (w_db_nonzero) begin
                    w_state_next = S_WAIT_RELEASE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_PULSE: begin
                w_state_next = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (!w_db_nonzero) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WAIT_RELEASE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_take_hit = (r_state == S_IDLE) && (w_state_next == S_PULSE);

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_hit_valid <= 1'b0;
            r_hit_id    <= {HOLE_ID_W{1'b0}};
            r_hit_multi <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hit_valid <= (w_state_next == S_PULSE);
            r_busy      <= (w_state_next == S_PULSE) || (w_state_next == S_WAIT_RELEASE);
            if (w_take_hit) begin
                r_hit_id    <= lowest_set_index(w_db_code);
                r_hit_multi <= more_than_one_set(w_db_code);
            end else begin
                r_hit_id    <= r_hit_id;
                r_hit_multi <= r_hit_multi;
            end
        end
    end

    // Saturating hit counter; a clear request beats a coincident pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hit_count <= {HIT_COUNT_W{1'b0}};
        end else if (clear_count) begin
            r_hit_count <= {HIT_COUNT_W{1'b0}};
        end else if (r_hit_valid && (r_hit_count != COUNT_MAX)) begin
            r_hit_count <= r_hit_count + HIT_COUNT_W'(1);
        end else begin
            r_hit_count <= r_hit_count;
        end
    end

    assign hit_valid = r_hit_valid;
    assign hit_id    = r_hit_id;
    assign hit_multi = r_hit_multi;
    assign hit_count = r_hit_count;
    assign busy      = r_busy;

endmodule

// File: tb/tb_hit_decoder.sv
// Self-checking bench for hit_decoder with a short debounce window; directed
// scenarios plus a randomized segment stream checked against a press model.
module tb_hit_decoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] ard_hit;
    logic       enable;
    logic       clear_count;
    logic       hit_valid;
    logic [1:0] hit_id;
    logic       hit_multi;
    logic [7:0] hit_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] obs_id[$];
    logic       obs_multi[$];

    always #10 clk = ~clk;

    hit_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ard_hit     (ard_hit),
        .enable      (enable),
        .clear_count (clear_count),
        .hit_valid   (hit_valid),
        .hit_id      (hit_id),
        .hit_multi   (hit_multi),
        .hit_count   (hit_count),
        .busy        (busy)
    );

    // Pulse monitor: records every cycle in which hit_valid is high.
    always @(posedge clk) begin
        #2;
        if (hit_valid === 1'b1) begin
            obs_id.push_back(hit_id);
            obs_multi.push_back(hit_multi);
        end
    end

    function automatic logic [1:0] model_id(input logic [3:0] code);
        for (int i = 0; i < 4; i++) begin
            if (code[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic model_multi(input logic [3:0] code);
        return ($countones(code) > 1);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; ard_hit = 4'd0; enable = 1'b0; clear_count = 1'b0;
        cycles(3);
        resetn = 1'b1;
        cycles(2 * D + 6);
        obs_id.delete();
        obs_multi.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; ard_hit = 4'b1111; enable = 1'b1; clear_count = 1'b0;
        cycles(3);
        checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", hit_valid); end
        checks++; if (hit_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", hit_id); end
        checks++; if (hit_multi !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", hit_multi); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", hit_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_latency();
        do_reset();
        enable = 1'b1;
        ard_hit = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (hit_valid !== (k == D + 3)) begin
                errors++;
                $display("FAIL latency_edge%0d got %b want %b", k, hit_valid, (k == D + 3));
            end
        end
        checks++; if (hit_id !== 2'd2) begin errors++; $display("FAIL latency_id got %0d want 2", hit_id); end
        checks++; if (hit_multi !== 1'b0) begin errors++; $display("FAIL latency_multi got %b want 0", hit_multi); end
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL latency_count got %0d want 1", hit_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy_held got %b want 1", busy); end
        ard_hit = 4'd0;
        cycles(D + 8);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL latency_busy_rel got %b want 0", busy); end
        checks++; if (obs_id.size() != 1) begin errors++; $display("FAIL latency_npulse got %0d want 1", obs_id.size()); end
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1;
        ard_hit = 4'b0010;
        cycles(3);
        ard_hit = 4'd0;
        cycles(20);
        checks++; if (obs_id.size() != 0) begin errors++; $display("FAIL glitch_npulse got %0d want 0", obs_id.size()); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", hit_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
    endtask

    task automatic test_multi();
        do_reset();
        enable = 1'b1;
        ard_hit = 4'b1010;
        cycles(20);
        checks++;
        if (obs_id.size() != 1) begin
            errors++; $display("FAIL multi_npulse got %0d want 1", obs_id.size());
        end else if (obs_id[0] !== 2'd1 || obs_multi[0] !== 1'b1) begin
            errors++; $display("FAIL multi_code got id=%0d multi=%b want id=1 multi=1", obs_id[0], obs_multi[0]);
        end
        ard_hit = 4'b1000;
        cycles(20);
        checks++; if (obs_id.size() != 1) begin errors++; $display("FAIL multi_nochange got %0d want 1", obs_id.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL multi_busy got %b want 1", busy); end
        ard_hit = 4'd0;
        cycles(20);
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL multi_count got %0d want 1", hit_count); end
    endtask

    task automatic test_enable_gate();
        do_reset();
        enable = 1'b0;
        ard_hit = 4'b0001;
        cycles(15);
        enable = 1'b1;
        cycles(10);
        checks++; if (obs_id.size() != 0) begin errors++; $display("FAIL gate_held got %0d want 0", obs_id.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy got %b want 1", busy); end
        ard_hit = 4'd0;
        cycles(15);
        ard_hit = 4'b0001;
        cycles(20);
        checks++;
        if (obs_id.size() != 1) begin
            errors++; $display("FAIL gate_npulse got %0d want 1", obs_id.size());
        end else if (obs_id[0] !== 2'd0) begin
            errors++; $display("FAIL gate_id got %0d want 0", obs_id[0]);
        end
        ard_hit = 4'd0;
        cycles(15);
    endtask

    task automatic test_saturation();
        logic [3:0] code;
        bit seen;
        do_reset();
        enable = 1'b1;
        for (int n = 0; n < 256; n++) begin
            code = 4'($urandom_range(1, 15));
            ard_hit = code;
            cycles(D + 6);
            ard_hit = 4'd0;
            cycles(D + 6);
            if (n == 254) begin
                checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", hit_count); end
            end
        end
        checks++; if (hit_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", hit_count); end
        checks++; if (obs_id.size() != 256) begin errors++; $display("FAIL sat_npulse got %0d want 256", obs_id.size()); end
        ard_hit = 4'b0010;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (hit_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL sat_clear_timeout got no pulse want pulse");
        end else begin
            clear_count = 1'b1;
            @(negedge clk);
            clear_count = 1'b0;
            if (hit_count !== 8'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", hit_count); end
        end
        ard_hit = 4'd0;
        cycles(15);
    endtask

    task automatic test_reset_pulse();
        bit seen;
        do_reset();
        enable = 1'b1;
        ard_hit = 4'b1000;
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (hit_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstpulse_timeout got no pulse want pulse"); end
        resetn = 1'b0;
        ard_hit = 4'd0;
        cycles(2);
        resetn = 1'b1;
        cycles(20);
        checks++; if (obs_id.size() != 1) begin errors++; $display("FAIL rstpulse_npulse got %0d want 1", obs_id.size()); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL rstpulse_count got %0d want 0", hit_count); end
    endtask

    task automatic test_reset_hold();
        do_reset();
        enable = 1'b1;
        ard_hit = 4'b0110;
        cycles(20);
        resetn = 1'b0;
        enable = 1'b0;
        cycles(2);
        checks++; if (hit_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rsthold_flags got valid=%b busy=%b want 0 0", hit_valid, busy); end
        checks++; if (hit_id !== 2'd0 || hit_multi !== 1'b0) begin errors++; $display("FAIL rsthold_code got id=%0d multi=%b want 0 0", hit_id, hit_multi); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL rsthold_count got %0d want 0", hit_count); end
        resetn = 1'b1;
        cycles(20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rsthold_swallow got busy=%b want 1", busy); end
        enable = 1'b1;
        ard_hit = 4'd0;
        cycles(15);
        ard_hit = 4'b0110;
        cycles(20);
        checks++; if (obs_id.size() != 2) begin errors++; $display("FAIL rsthold_npulse got %0d want 2", obs_id.size()); end
        checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL rsthold_count2 got %0d want 1", hit_count); end
        ard_hit = 4'd0;
        cycles(15);
    endtask

    task automatic test_held_after_reset();
        @(negedge clk);
        resetn = 1'b0; enable = 1'b1; clear_count = 1'b0; ard_hit = 4'b0010;
        cycles(3);
        obs_id.delete();
        obs_multi.delete();
        resetn = 1'b1;
        cycles(20);
        checks++;
        if (obs_id.size() != 1) begin
            errors++; $display("FAIL held_npulse got %0d want 1", obs_id.size());
        end else if (obs_id[0] !== 2'd1) begin
            errors++; $display("FAIL held_id got %0d want 1", obs_id[0]);
        end
        ard_hit = 4'd0;
        cycles(15);
    endtask

    task automatic test_random();
        logic [3:0] val;
        logic [3:0] prev_val;
        logic [3:0] last_acc;
        logic       en;
        bit         armed;
        int         len;
        logic [1:0] exp_id[$];
        logic       exp_multi[$];
        do_reset();
        prev_val = 4'd0; last_acc = 4'd0; armed = 1'b1; en = 1'b0;
        for (int s = 0; s < 80; s++) begin
            do val = 4'($urandom_range(0, 15)); while (val == prev_val);
            if ($urandom_range(0, 2) != 0) begin
                en = 1'($urandom_range(0, 1));
                enable = en;
                len = $urandom_range(D + 6, D + 12);
                if (val != last_acc) begin
                    if (val == 4'd0) begin
                        armed = 1'b1;
                    end else if (armed) begin
                        armed = 1'b0;
                        if (en) begin
                            exp_id.push_back(model_id(val));
                            exp_multi.push_back(model_multi(val));
                        end
                    end
                    last_acc = val;
                end
            end else begin
                len = $urandom_range(1, D - 1);
            end
            ard_hit = val;
            prev_val = val;
            cycles(len);
        end
        ard_hit = 4'd0;
        cycles(20);
        checks++;
        if (obs_id.size() != exp_id.size()) begin
            errors++; $display("FAIL rand_npulse got %0d want %0d", obs_id.size(), exp_id.size());
        end else begin
            for (int i = 0; i < exp_id.size(); i++) begin
                if (obs_id[i] !== exp_id[i] || obs_multi[i] !== exp_multi[i]) begin
                    errors++;
                    $display("FAIL rand_pulse%0d got id=%0d multi=%b want id=%0d multi=%b",
                             i, obs_id[i], obs_multi[i], exp_id[i], exp_multi[i]);
                end
            end
        end
        checks++;
        if (hit_count !== 8'(exp_id.size())) begin
            errors++; $display("FAIL rand_count got %0d want %0d", hit_count, exp_id.size());
        end
    endtask

    initial begin
        resetn = 1'b0; ard_hit = 4'd0; enable = 1'b0; clear_count = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_multi();
        test_enable_gate();
        test_saturation();
        test_reset_pulse();
        test_reset_hold();
        test_held_after_reset();
        test_random();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
